tone_detector: RTL and testbench

//  Receive side of the game's square-wave sound line: measures the period of an incoming tone and

---
 rtl/tone_detector.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_tone_detector.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// -----------------------------------------------------------------------------
// tone_detector
//   Receive side of the game's square-wave sound line. Measures the period
//   between rising edges of sound_in and classifies it as one of four game
//   tones (196/262/330/784 Hz -> idx 0..3). A tone is reported only after
//   CONFIRM consecutive identical classifications. Silence is declared when
//   no rising edge has been seen for SILENCE_MS milliseconds.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous reset, active low
//   ticks_per_milli  clk cycles per millisecond (0 treated as 1)
//   sound_in         square-wave input, asynchronous to clk
//   tone_valid       high while a tone is locked
//   tone_idx         index of locked tone (holds last value when not valid)
//   tone_start       1-cycle pulse when a tone locks
//   tone_end         1-cycle pulse when a locked tone ends
//   silent           high while in the SILENT state
//   last_period      most recent measured period in cycles
// -----------------------------------------------------------------------------
module tone_detector #(
    parameter int PERIOD_W   = 20,
    parameter int CONFIRM    = 3,
    parameter int TOL_SHIFT  = 4,
    parameter int SILENCE_MS = 20,
    parameter int MIN_PERIOD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         ticks_per_milli,
    input  logic                sound_in,
    output logic                tone_valid,
    output logic [1:0]          tone_idx,
    output logic                tone_start,
    output logic                tone_end,
    output logic                silent,
    output logic [PERIOD_W-1:0] last_period
);

    localparam int CNT_W = $clog2(CONFIRM + 1);
    localparam int MS_W  = $clog2(SILENCE_MS + 1);

    typedef enum logic [1:0] {
        S_SILENT,
        S_RUN,
        S_CLASSIFY
    } state_t;

    state_t r_state, w_state_next;

    // Input synchronizer and rising-edge register
    logic r_sync1, r_sync2, r_sync3, r_edge;

    // Period counter and millisecond timer
    logic [PERIOD_W-1:0] r_count;
    logic [15:0]         r_tick;
    logic [MS_W-1:0]     r_ms;

    // Edge held while classifying (one deep)
    logic                r_held;
    logic [PERIOD_W-1:0] r_held_p;

    // Classification datapath
    logic [PERIOD_W-1:0] r_p;
    logic [1:0]          r_k;
    logic                r_found;
    logic [1:0]          r_found_idx;

    // Match tracking and outputs
    logic [CNT_W-1:0]    r_match_cnt;
    logic                r_prev_none;
    logic [1:0]          r_prev_idx;
    logic                r_valid;
    logic [1:0]          r_idx;
    logic                r_start;
    logic                r_end;
    logic [PERIOD_W-1:0] r_last_period;

    // Combinational helpers
    logic [15:0]         w_tpm;
    logic [31:0]         w_tps;
    logic [31:0]         w_tol;
    logic [31:0]         w_freq;
    logic [31:0]         w_prod;
    logic [31:0]         w_diff;
    logic                w_hit;
    logic                w_evt;
    logic [PERIOD_W-1:0] w_event_p;
    logic                w_take;
    logic                w_held_set;
    logic                w_held_clear;
    logic                w_cand_strobe;
    logic                w_cand_none;
    logic [1:0]          w_cand_idx;
    logic                w_enter_silent;
    logic                w_same;
    logic [CNT_W-1:0]    w_cnt_next;

    assign w_tpm = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
    assign w_tps = {16'd0, w_tpm} * 32'd1000;
    assign w_tol = w_tps >> TOL_SHIFT;

    // Tone k is tested in classify cycle k: |P*f_k - tps| <= tol
    always_comb begin
        w_freq = 32'd196;
        case (r_k)
            2'd0: w_freq = 32'd196;
            2'd1: w_freq = 32'd262;
            2'd2: w_freq = 32'd330;
            2'd3: w_freq = 32'd784;
            default: w_freq = 32'd196;
        endcase
    end

    assign w_prod = 32'(r_p) * w_freq;
    assign w_diff = (w_prod >= w_tps) ? (w_prod - w_tps) : (w_tps - w_prod);
    assign w_hit  = (w_diff <= w_tol);

    // A held edge is always older than a fresh one, so it is consumed first
    assign w_evt     = r_edge | r_held;
    assign w_event_p = r_held ? r_held_p : r_count;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of all others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_SILENT;
        else        r_state <= w_state_next;
    end

    // ------------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_take         = 1'b0;
        w_held_set     = 1'b0;
        w_held_clear   = 1'b0;
        w_cand_strobe  = 1'b0;
        w_cand_none    = 1'b1;
        w_cand_idx     = 2'd0;
        w_enter_silent = 1'b0;

        case (r_state)
            S_SILENT: begin
                // First edge is only a timing reference
                if (r_edge) w_state_next = S_RUN;
            end

            S_RUN: begin
                if (w_evt) begin
                    w_take       = 1'b1;
                    w_held_clear = r_held;
                    // Fresh edge in the same cycle as a held one: keep it
                    if (r_held && r_edge) w_held_set = 1'b1;
                    if ((w_event_p < PERIOD_W'(MIN_PERIOD)) || (&w_event_p)) begin
                        w_cand_strobe = 1'b1;
                        w_cand_none   = 1'b1;
                    end else begin
                        w_state_next = S_CLASSIFY;
                    end
                end else if (r_ms == MS_W'(SILENCE_MS)) begin
                    w_state_next   = S_SILENT;
                    w_enter_silent = 1'b1;
                end
            end

            S_CLASSIFY: begin
                if (r_edge) w_held_set = 1'b1;
                if (r_k == 2'd3) begin
                    w_state_next  = S_RUN;
                    w_cand_strobe = 1'b1;
                    w_cand_none   = !(r_found || w_hit);
                    w_cand_idx    = r_found ? r_found_idx : 2'd3;
                end
            end

            default: w_state_next = S_SILENT;
        endcase
    end

    // Match counter update for the candidate presented this cycle
    always_comb begin
        w_same = !w_cand_none && !r_prev_none && (w_cand_idx == r_prev_idx);
        if (w_same)
            w_cnt_next = (r_match_cnt == CNT_W'(CONFIRM)) ? r_match_cnt
                                                          : r_match_cnt + CNT_W'(1);
        else
            w_cnt_next = w_cand_none ? CNT_W'(0) : CNT_W'(1);
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync3       <= 1'b0;
            r_edge        <= 1'b0;
            r_count       <= '0;
            r_tick        <= '0;
            r_ms          <= '0;
            r_held        <= 1'b0;
            r_held_p      <= '0;
            r_p           <= '0;
            r_k           <= 2'd0;
            r_found       <= 1'b0;
            r_found_idx   <= 2'd0;
            r_match_cnt   <= '0;
            r_prev_none   <= 1'b1;
            r_prev_idx    <= 2'd0;
            r_valid       <= 1'b0;
            r_idx         <= 2'd0;
            r_start       <= 1'b0;
            r_end         <= 1'b0;
            r_last_period <= '0;
        end else begin
            r_sync1 <= sound_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;

            // Period counter restarts at 1 so the captured value equals the period
            if (r_edge)        r_count <= PERIOD_W'(1);
            else if (!(&r_count)) r_count <= r_count + PERIOD_W'(1);

            if (r_edge) begin
                r_tick <= '0;
                r_ms   <= '0;
            end else if (r_tick >= (w_tpm - 16'd1)) begin
                r_tick <= '0;
                if (r_ms != MS_W'(SILENCE_MS)) r_ms <= r_ms + MS_W'(1);
            end else begin
                r_tick <= r_tick + 16'd1;
            end

            if (w_held_set) begin
                r_held   <= 1'b1;
                r_held_p <= r_count;
            end else if (w_held_clear) begin
                r_held   <= 1'b0;
            end

            if (w_take) begin
                r_p           <= w_event_p;
                r_last_period <= w_event_p;
                r_k           <= 2'd0;
                r_found       <= 1'b0;
            end else if (r_state == S_CLASSIFY) begin
                r_k <= r_k + 2'd1;
                if (w_hit && !r_found) begin
                    r_found     <= 1'b1;
                    r_found_idx <= r_k;
                end
            end

            r_start <= 1'b0;
            r_end   <= 1'b0;

            if (w_cand_strobe) begin
                r_match_cnt <= w_cnt_next;
                r_prev_none <= w_cand_none;
                r_prev_idx  <= w_cand_idx;
                if (!r_valid && (w_cnt_next == CNT_W'(CONFIRM))) begin
                    r_valid <= 1'b1;
                    r_idx   <= w_cand_idx;
                    r_start <= 1'b1;
                end else if (r_valid && (w_cand_none || (w_cand_idx != r_idx))) begin
                    r_valid <= 1'b0;
                    r_end   <= 1'b1;
                end
            end

            if (w_enter_silent) begin
                r_match_cnt <= '0;
                r_prev_none <= 1'b1;
                if (r_valid) begin
                    r_valid <= 1'b0;
                    r_end   <= 1'b1;
                end
            end
        end
    end

    assign tone_valid  = r_valid;
    assign tone_idx    = r_idx;
    assign tone_start  = r_start;
    assign tone_end    = r_end;
    assign silent      = (r_state == S_SILENT);
    assign last_period = r_last_period;

endmodule

// File: tb/tb_tone_detector.sv
// -----------------------------------------------------------------------------
// tb_tone_detector
//   Drives square waves of chosen periods into tone_detector. A reference
//   model of edge classification and match/lock logic pushes expected
//   tone_start/tone_end pulses (kind, index, cycle) into a scoreboard queue;
//   pulses from the DUT are popped and compared as they appear.
// -----------------------------------------------------------------------------
module tb_tone_detector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ticks_per_milli = 16'd50;
    logic        sound_in = 1'b0;
    logic        tone_valid;
    logic [1:0]  tone_idx;
    logic        tone_start;
    logic        tone_end;
    logic        silent;
    logic [19:0] last_period;

    tone_detector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (ticks_per_milli),
        .sound_in        (sound_in),
        .tone_valid      (tone_valid),
        .tone_idx        (tone_idx),
        .tone_start      (tone_start),
        .tone_end        (tone_end),
        .silent          (silent),
        .last_period     (last_period)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_start;
        logic [1:0] idx;
        int         at;
    } ev_t;

    ev_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    bit m_silent    = 1'b1;
    bit m_locked    = 1'b0;
    int m_cnt       = 0;
    int m_prev      = -1;
    int m_idx       = 0;
    int m_last_p    = 0;
    int last_rise   = 0;

    // Spec classification at tps = 50000, tolerance = 50000 >> 4
    function automatic int exp_cand(input int p);
        int  f[4] = '{196, 262, 330, 784};
        longint prod;
        longint d;
        if (p < 8) return -1;
        for (int k = 0; k < 4; k++) begin
            prod = longint'(p) * f[k];
            d = prod - 50000;
            if (d < 0) d = -d;
            if (d <= 3125) return k;
        end
        return -1;
    endfunction

    // Rise driven in cycle d is sampled at d+1; outputs update 7 cycles later
    task automatic model_rise(input int d);
        int  p;
        int  c;
        ev_t e;
        if (m_silent) begin
            m_silent  = 1'b0;
            last_rise = d;
            return;
        end
        p = d - last_rise;
        last_rise = d;
        m_last_p = p;
        c = exp_cand(p);
        if (c >= 0 && c == m_prev) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
        else                       m_cnt = (c < 0) ? 0 : 1;
        m_prev = c;
        if (!m_locked && m_cnt == 3) begin
            m_locked = 1'b1;
            m_idx = c;
            e.is_start = 1'b1; e.idx = 2'(c); e.at = d + 8;
            sb.push_back(e);
        end else if (m_locked && c != m_idx) begin
            m_locked = 1'b0;
            e.is_start = 1'b0; e.idx = 2'(m_idx); e.at = d + 8;
            sb.push_back(e);
        end
    endtask

    task automatic model_silence(input int at);
        ev_t e;
        m_silent = 1'b1;
        if (m_locked) begin
            e.is_start = 1'b0; e.idx = 2'(m_idx); e.at = at;
            sb.push_back(e);
        end
        m_locked = 1'b0;
        m_cnt    = 0;
        m_prev   = -1;
    endtask

    task automatic monitor();
        ev_t e;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            checks++; failures++;
            $display("FAIL sb_missed: got no pulse, required %s idx=%0d at cycle %0d (now %0d)",
                     e.is_start ? "start" : "end", e.idx, e.at, cyc);
        end
        if (tone_start || tone_end) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got start=%0b end=%0b idx=%0d at cycle %0d, required no pulse",
                         tone_start, tone_end, tone_idx, cyc);
            end else begin
                e = sb.pop_front();
                if (tone_start !== e.is_start || tone_end !== !e.is_start ||
                    (e.is_start && tone_idx !== e.idx) || cyc != e.at) begin
                    failures++;
                    $display("FAIL sb_pulse: got start=%0b end=%0b idx=%0d cycle=%0d, required start=%0b end=%0b idx=%0d cycle=%0d",
                             tone_start, tone_end, tone_idx, cyc, e.is_start, !e.is_start, e.idx, e.at);
                end
            end
        end
    endtask

    // One clock cycle with sound_in = v
    task automatic tick(input logic v);
        if (v && !sound_in) model_rise(cyc);
        sound_in = v;
        // Silence transition: 20 ms (1000 cycles) after the timer clears at d+4
        if (!m_silent && cyc == last_rise + 1005) model_silence(cyc);
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic gen(input int per, input int high, input int n);
        for (int j = 0; j < n; j++)
            for (int i = 0; i < per; i++)
                tick(i < high);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic drain(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending expected pulses, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({tone_valid, tone_idx, tone_start, tone_end, silent} !== 6'b000001 || last_period !== 20'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%0b idx=%0d start=%0b end=%0b silent=%0b lp=%0d, required 0/0/0/0/1/0",
                     tone_valid, tone_idx, tone_start, tone_end, silent, last_period);
        end
        rst_n = 1'b1;
        idle(5);
        checks++;
        if (silent !== 1'b1) begin
            failures++;
            $display("FAIL reset_silent_idle: got %0b required 1", silent);
        end
    endtask

    task automatic test_g3_lock();
        gen(255, 128, 6);
        checks++;
        if (tone_valid !== 1'b1 || tone_idx !== 2'd0) begin
            failures++;
            $display("FAIL g3_lock: got valid=%0b idx=%0d required 1/0", tone_valid, tone_idx);
        end
        checks++;
        if (last_period !== 20'(m_last_p) || silent !== 1'b0) begin
            failures++;
            $display("FAIL g3_period: got lp=%0d silent=%0b required lp=%0d silent=0", last_period, silent, m_last_p);
        end
        idle(1010);
        checks++;
        if (silent !== 1'b1 || tone_valid !== 1'b0 || tone_idx !== 2'd0) begin
            failures++;
            $display("FAIL g3_silence: got silent=%0b valid=%0b idx=%0d required 1/0/0", silent, tone_valid, tone_idx);
        end
        drain("g3");
    endtask

    task automatic test_g5_jitter();
        for (int j = 0; j < 4; j++) begin
            gen(63, 32, 1);
            gen(64, 32, 1);
        end
        checks++;
        if (tone_valid !== 1'b1 || tone_idx !== 2'd3) begin
            failures++;
            $display("FAIL g5_lock: got valid=%0b idx=%0d required 1/3", tone_valid, tone_idx);
        end
        checks++;
        if (last_period !== 20'(m_last_p)) begin
            failures++;
            $display("FAIL g5_period: got %0d required %0d", last_period, m_last_p);
        end
        idle(1100);
        drain("g5");
    endtask

    task automatic test_tone_change();
        gen(191, 96, 5);
        checks++;
        if (tone_valid !== 1'b1 || tone_idx !== 2'd1) begin
            failures++;
            $display("FAIL c4_lock: got valid=%0b idx=%0d required 1/1", tone_valid, tone_idx);
        end
        gen(152, 76, 5);
        checks++;
        if (tone_valid !== 1'b1 || tone_idx !== 2'd2) begin
            failures++;
            $display("FAIL e4_lock: got valid=%0b idx=%0d required 1/2", tone_valid, tone_idx);
        end
        idle(1100);
        drain("change");
    endtask

    task automatic test_tolerance();
        gen(240, 120, 5);
        checks++;
        if (tone_valid !== 1'b1 || tone_idx !== 2'd0) begin
            failures++;
            $display("FAIL tol_edge_lock: got valid=%0b idx=%0d required 1/0", tone_valid, tone_idx);
        end
        gen(239, 120, 2);
        checks++;
        if (tone_valid !== 1'b0 || last_period !== 20'd239) begin
            failures++;
            $display("FAIL tol_outside: got valid=%0b lp=%0d required 0/239", tone_valid, last_period);
        end
        idle(1100);
        drain("tol");
    endtask

    task automatic test_no_tone();
        gen(120, 60, 6);
        checks++;
        if (tone_valid !== 1'b0 || silent !== 1'b0 || last_period !== 20'd120) begin
            failures++;
            $display("FAIL notone_run: got valid=%0b silent=%0b lp=%0d required 0/0/120", tone_valid, silent, last_period);
        end
        idle(1100);
        checks++;
        if (silent !== 1'b1) begin
            failures++;
            $display("FAIL notone_silence: got silent=%0b required 1", silent);
        end
        drain("notone");
    endtask

    task automatic test_glitch();
        gen(255, 128, 5);
        // One G3 period with a 3-cycle pulse shortly after the falling edge
        for (int i = 0; i < 255; i++) tick((i < 128) || (i >= 130 && i < 133));
        checks++;
        if (tone_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_drop: got valid=%0b required 0", tone_valid);
        end
        gen(255, 128, 4);
        checks++;
        if (tone_valid !== 1'b1 || tone_idx !== 2'd0) begin
            failures++;
            $display("FAIL glitch_relock: got valid=%0b idx=%0d required 1/0", tone_valid, tone_idx);
        end
        idle(1100);
        drain("glitch");
    endtask

    task automatic test_reset_mid_lock();
        gen(255, 128, 5);
        checks++;
        if (tone_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_prelock: got valid=%0b required 1", tone_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tone_valid, tone_idx, tone_start, tone_end, silent} !== 6'b000001 || last_period !== 20'd0) begin
            failures++;
            $display("FAIL rst_async: got valid=%0b idx=%0d start=%0b end=%0b silent=%0b lp=%0d, required 0/0/0/0/1/0",
                     tone_valid, tone_idx, tone_start, tone_end, silent, last_period);
        end
        m_silent = 1'b1; m_locked = 1'b0; m_cnt = 0; m_prev = -1;
        idle(4);
        rst_n = 1'b1;
        idle(20);
        checks++;
        if (silent !== 1'b1 || tone_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_after: got silent=%0b valid=%0b required 1/0", silent, tone_valid);
        end
        drain("rst");
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_g3_lock();
        test_g5_jitter();
        test_tone_change();
        test_tolerance();
        test_no_tone();
        test_glitch();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
